// File: rtl/gcd_wrapper_pkg.sv
// Shared definitions for the GCD wrapper: default widths agreed with the AXI
// unpacker, default timing constants and the job sequencer state encoding.
package gcd_wrapper_pkg;

   localparam int unsigned GCD_ARG_W          = 1279;
   localparam int unsigned GCD_RES_W          = 1284;
   localparam int unsigned GCD_SETTLE_CYCLES  = 32;
   localparam int unsigned GCD_TIMEOUT_CYCLES = 1000000;
   localparam int unsigned GCD_CNT_W          = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_LAUNCH,
      ST_BUSY,
      ST_HOLD
   } gcd_state_e;

endpackage

// File: rtl/gcd_stable_detect.sv
// Operand stability detector: shadows both operand buses, flags any change
// and counts down a settle window while the sequencer is waiting to launch.
module gcd_stable_detect
   import gcd_wrapper_pkg::*;
#(
   parameter int unsigned ARG_W         = GCD_ARG_W,
   parameter int unsigned SETTLE_CYCLES = GCD_SETTLE_CYCLES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [ARG_W-1:0] arg_a,
   input  logic [ARG_W-1:0] arg_b,
   input  logic             count_en,
   output logic             chg,
   output logic             settled
);

   localparam int unsigned     SC_W    = $clog2(SETTLE_CYCLES + 1);
   localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE_CYCLES);
   localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);

   logic [ARG_W-1:0] prev_a_q, prev_a_d;
   logic [ARG_W-1:0] prev_b_q, prev_b_d;
   logic [SC_W-1:0]  cnt_q, cnt_d;

   // Change detect, settle pulse and down-counter next value.
   always_comb begin
      // NOTE: every signal written here gets a default before any branch, so no latch is inferred.
      prev_a_d = arg_a;
      prev_b_d = arg_b;
      chg      = (arg_a != prev_a_q) || (arg_b != prev_b_q);
      settled  = count_en && !chg && (cnt_q == SC_ONE);
      cnt_d    = cnt_q;
      // The window restarts on any change and sits preloaded while not counting,
      // so every entry into the settle phase sees a full window.
      if (!count_en || chg) begin
         cnt_d = SC_LOAD;
      end else if (cnt_q > SC_ONE) begin
         cnt_d = cnt_q - SC_ONE;
      end
   end

   // Shadow registers and settle counter.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         // NOTE: the wide shadows are reset on purpose: zero shadows make all-zero operands look unchanged.
         prev_a_q <= '0;
         prev_b_q <= '0;
         cnt_q    <= SC_LOAD;
      end else begin
         prev_a_q <= prev_a_d;
         prev_b_q <= prev_b_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/gcd_job_sequencer.sv
// GCD job sequencer: waits for stable operands, launches one job on the core,
// collects results or times out, and holds DONE until the operands change.
module gcd_job_sequencer
   import gcd_wrapper_pkg::*;
#(
   parameter int unsigned ARG_W          = GCD_ARG_W,
   parameter int unsigned RES_W          = GCD_RES_W,
   parameter int unsigned SETTLE_CYCLES  = GCD_SETTLE_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = GCD_TIMEOUT_CYCLES,
   parameter int unsigned CNT_W          = GCD_CNT_W
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic [ARG_W-1:0] ARG_A,
   input  logic [ARG_W-1:0] ARG_B,
   output logic             DONE,
   output logic [RES_W-1:0] RESULT_A,
   output logic [RES_W-1:0] RESULT_B,
   output logic             GCD_START,
   output logic [ARG_W-1:0] GCD_A,
   output logic [ARG_W-1:0] GCD_B,
   input  logic             GCD_DONE,
   input  logic [RES_W-1:0] GCD_RES_A,
   input  logic [RES_W-1:0] GCD_RES_B,
   output logic             TIMEOUT,
   output logic [CNT_W-1:0] BUSY_CYCLES
);

   localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

   gcd_state_e       state_q, state_d;
   logic             restart_q, restart_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;
   logic [RES_W-1:0] res_a_q, res_a_d;
   logic [RES_W-1:0] res_b_q, res_b_d;
   logic [ARG_W-1:0] gcd_a_q, gcd_a_d;
   logic [ARG_W-1:0] gcd_b_q, gcd_b_d;
   logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
   logic [CNT_W-1:0] busy_cycles_q, busy_cycles_d;
   logic [CNT_W-1:0] busy_inc;
   logic             settle_en;
   logic             chg;
   logic             settled;

   assign settle_en = (state_q == ST_SETTLE);

   gcd_stable_detect #(
      .ARG_W        (ARG_W),
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_stable_detect (
      .clk     (CLK),
      .rst_n   (RESETn),
      .arg_a   (ARG_A),
      .arg_b   (ARG_B),
      .count_en(settle_en),
      .chg     (chg),
      .settled (settled)
   );

   // Next-state, capture and busy-counter logic.
   always_comb begin
      state_d       = state_q;
      restart_d     = restart_q;
      done_d        = done_q;
      timeout_d     = timeout_q;
      res_a_d       = res_a_q;
      res_b_d       = res_b_q;
      gcd_a_d       = gcd_a_q;
      gcd_b_d       = gcd_b_q;
      busy_cnt_d    = busy_cnt_q;
      busy_cycles_d = busy_cycles_q;
      busy_inc      = (busy_cnt_q == '1) ? busy_cnt_q : busy_cnt_q + CNT_ONE;

      case (state_q)
         ST_IDLE: begin
            if (chg) begin
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settled) begin
               gcd_a_d = ARG_A;
               gcd_b_d = ARG_B;
               state_d = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            // A change arriving in the launch cycle already invalidates this job.
            busy_cnt_d = '0;
            timeout_d  = 1'b0;
            restart_d  = chg;
            state_d    = ST_BUSY;
         end
         ST_BUSY: begin
            busy_cnt_d = busy_inc;
            if (GCD_DONE) begin
               if (restart_q || chg) begin
                  // Operands moved under the running job: drop its results.
                  restart_d = 1'b0;
                  state_d   = ST_SETTLE;
               end else begin
                  res_a_d       = GCD_RES_A;
                  res_b_d       = GCD_RES_B;
                  busy_cycles_d = busy_inc;
                  timeout_d     = 1'b0;
                  done_d        = 1'b1;
                  state_d       = ST_HOLD;
               end
            end else if (busy_inc >= TIMEOUT_LIMIT) begin
               res_a_d       = '0;
               res_b_d       = '0;
               busy_cycles_d = busy_inc;
               timeout_d     = 1'b1;
               done_d        = 1'b1;
               restart_d     = 1'b0;
               state_d       = ST_HOLD;
            end else if (chg) begin
               restart_d = 1'b1;
            end
         end
         ST_HOLD: begin
            if (chg) begin
               done_d    = 1'b0;
               restart_d = 1'b0;
               state_d   = ST_SETTLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, capture and counter registers.
   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         state_q       <= ST_IDLE;
         restart_q     <= 1'b0;
         done_q        <= 1'b0;
         timeout_q     <= 1'b0;
         res_a_q       <= '0;
         res_b_q       <= '0;
         gcd_a_q       <= '0;
         gcd_b_q       <= '0;
         busy_cnt_q    <= '0;
         busy_cycles_q <= '0;
      end else begin
         state_q       <= state_d;
         restart_q     <= restart_d;
         done_q        <= done_d;
         timeout_q     <= timeout_d;
         res_a_q       <= res_a_d;
         res_b_q       <= res_b_d;
         gcd_a_q       <= gcd_a_d;
         gcd_b_q       <= gcd_b_d;
         busy_cnt_q    <= busy_cnt_d;
         busy_cycles_q <= busy_cycles_d;
      end
   end

   // The launch pulse is masked while reset is held so the core never sees it then.
   assign GCD_START   = (state_q == ST_LAUNCH) && RESETn;
   assign DONE        = done_q;
   assign TIMEOUT     = timeout_q;
   assign RESULT_A    = res_a_q;
   assign RESULT_B    = res_b_q;
   assign GCD_A       = gcd_a_q;
   assign GCD_B       = gcd_b_q;
   assign BUSY_CYCLES = busy_cycles_q;

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Self-checking bench for gcd_job_sequencer: directed operand sequences, a
// simple GCD core that answers a set number of cycles after START, and a
// timeline model of the sequencer compared against the DUT every cycle.
module tb_gcd_job_sequencer;

   localparam int unsigned ARG_W  = 1279;
   localparam int unsigned RES_W  = 1284;
   localparam int unsigned CNT_W  = 32;
   localparam int unsigned SETTLE = 4;
   localparam int unsigned TMO    = 16;

   logic             CLK = 1'b0;
   logic             RESETn = 1'b0;
   logic [ARG_W-1:0] ARG_A = '0;
   logic [ARG_W-1:0] ARG_B = '0;
   logic             DONE;
   logic [RES_W-1:0] RESULT_A;
   logic [RES_W-1:0] RESULT_B;
   logic             GCD_START;
   logic [ARG_W-1:0] GCD_A;
   logic [ARG_W-1:0] GCD_B;
   logic             GCD_DONE = 1'b0;
   logic [RES_W-1:0] GCD_RES_A = '0;
   logic [RES_W-1:0] GCD_RES_B = '0;
   logic             TIMEOUT;
   logic [CNT_W-1:0] BUSY_CYCLES;

   gcd_job_sequencer #(
      .ARG_W         (ARG_W),
      .RES_W         (RES_W),
      .SETTLE_CYCLES (SETTLE),
      .TIMEOUT_CYCLES(TMO),
      .CNT_W         (CNT_W)
   ) dut (
      .CLK        (CLK),
      .RESETn     (RESETn),
      .ARG_A      (ARG_A),
      .ARG_B      (ARG_B),
      .DONE       (DONE),
      .RESULT_A   (RESULT_A),
      .RESULT_B   (RESULT_B),
      .GCD_START  (GCD_START),
      .GCD_A      (GCD_A),
      .GCD_B      (GCD_B),
      .GCD_DONE   (GCD_DONE),
      .GCD_RES_A  (GCD_RES_A),
      .GCD_RES_B  (GCD_RES_B),
      .TIMEOUT    (TIMEOUT),
      .BUSY_CYCLES(BUSY_CYCLES)
   );

   always #5 CLK = ~CLK;

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned cyc      = 0;
   int          start_count = 0;

   always @(posedge CLK) cyc++;
   always @(negedge CLK) if (GCD_START === 1'b1) start_count++;

   task automatic check(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act[127:0], exp[127:0], cyc);
      end
   endtask

   function automatic logic [63:0] gcd64(input logic [63:0] a, input logic [63:0] b);
      logic [63:0] x = a;
      logic [63:0] y = b;
      logic [63:0] t;
      while (y != 0) begin
         t = y;
         y = x % y;
         x = t;
      end
      return x;
   endfunction

   // ---------------- GCD core model ----------------
   // core_n = cycles from START to GCD_DONE; 0 means the core never answers.
   int          core_n   = 5;
   int          core_rem = 0;
   logic [63:0] core_a   = '0;
   logic [63:0] core_b   = '0;

   always @(negedge CLK) begin
      if (GCD_START === 1'b1) begin
         core_rem = core_n;
         core_a   = GCD_A[63:0];
         core_b   = GCD_B[63:0];
      end
   end

   always @(posedge CLK) begin
      logic [63:0] g;
      #1;
      GCD_DONE  = 1'b0;
      GCD_RES_A = {RES_W{1'b1}};
      GCD_RES_B = {RES_W{1'b1}};
      if (core_rem > 0) begin
         core_rem--;
         if (core_rem == 0) begin
            g         = gcd64(core_a, core_b);
            GCD_DONE  = 1'b1;
            GCD_RES_A = '0;
            GCD_RES_B = '0;
            GCD_RES_A[63:0] = g;
            GCD_RES_B[63:0] = (g == 0) ? 64'd0 : (core_a / g) * core_b;
         end
      end
   end

   // ---------------- timeline model + per-cycle compare ----------------
   bit               m_owed    = 1'b0;
   bit               m_in_job  = 1'b0;
   bit               m_restart = 1'b0;
   int unsigned      m_quiet   = 0;
   logic [CNT_W-1:0] m_job_n   = '0;
   logic [ARG_W-1:0] m_prev_a  = '0;
   logic [ARG_W-1:0] m_prev_b  = '0;
   bit               e_start   = 1'b0;
   bit               e_done    = 1'b0;
   bit               e_to      = 1'b0;
   logic [RES_W-1:0] e_res_a   = '0;
   logic [RES_W-1:0] e_res_b   = '0;
   logic [CNT_W-1:0] e_busy    = '0;
   logic [ARG_W-1:0] e_gcd_a   = '0;
   logic [ARG_W-1:0] e_gcd_b   = '0;

   always @(negedge CLK) begin
      bit chg_m;
      bit n_start;
      check("cmp_start",    GCD_START,   e_start);
      check("cmp_done",     DONE,        e_done);
      check("cmp_timeout",  TIMEOUT,     e_to);
      check("cmp_result_a", RESULT_A,    e_res_a);
      check("cmp_result_b", RESULT_B,    e_res_b);
      check("cmp_busy",     BUSY_CYCLES, e_busy);
      check("cmp_gcd_a",    GCD_A,       e_gcd_a);
      check("cmp_gcd_b",    GCD_B,       e_gcd_b);

      // Work out what the outputs must be next cycle from this cycle's inputs.
      chg_m   = (ARG_A != m_prev_a) || (ARG_B != m_prev_b);
      n_start = 1'b0;
      if (RESETn !== 1'b1) begin
         m_owed = 0; m_in_job = 0; m_restart = 0; m_quiet = 0; m_job_n = '0;
         e_done = 0; e_to = 0; e_res_a = '0; e_res_b = '0; e_busy = '0;
         e_gcd_a = '0; e_gcd_b = '0;
         m_prev_a = '0; m_prev_b = '0;
      end else begin
         if (m_in_job) begin
            m_job_n = (m_job_n == '1) ? m_job_n : m_job_n + 32'd1;
            if (chg_m) m_restart = 1'b1;
            if (GCD_DONE === 1'b1) begin
               m_in_job = 1'b0;
               if (m_restart) begin
                  m_owed  = 1'b1;
                  m_quiet = 0;
               end else begin
                  e_done  = 1'b1;
                  e_to    = 1'b0;
                  e_res_a = GCD_RES_A;
                  e_res_b = GCD_RES_B;
                  e_busy  = m_job_n;
               end
            end else if (m_job_n >= TMO) begin
               m_in_job = 1'b0;
               e_done   = 1'b1;
               e_to     = 1'b1;
               e_res_a  = '0;
               e_res_b  = '0;
               e_busy   = m_job_n;
            end
         end else if (e_start) begin
            m_in_job  = 1'b1;
            m_job_n   = '0;
            e_to      = 1'b0;
            m_restart = chg_m;
         end else if (chg_m) begin
            m_owed  = 1'b1;
            m_quiet = 0;
            e_done  = 1'b0;
         end else if (m_owed) begin
            m_quiet++;
            if (m_quiet == SETTLE) begin
               n_start = 1'b1;
               m_owed  = 1'b0;
               e_gcd_a = ARG_A;
               e_gcd_b = ARG_B;
            end
         end
         m_prev_a = ARG_A;
         m_prev_b = ARG_B;
      end
      e_start = n_start;
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // which: 0 = GCD_START, 1 = DONE, otherwise GCD_DONE
   task automatic wait_sig(input int which, input string name, input int bound, output int at);
      bit seen = 1'b0;
      at = -1000;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge CLK);
         case (which)
            0:       seen = (GCD_START === 1'b1);
            1:       seen = (DONE === 1'b1);
            default: seen = (GCD_DONE === 1'b1);
         endcase
         if (seen) at = int'(cyc);
      end
      check({name, "_seen"}, seen, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c, s, s2, g, dn, s0;

      // Reset and quiet all-zero operands.
      RESETn = 1'b0;
      repeat (3) tick();
      @(negedge CLK);
      check("rst_done",    DONE,        1'b0);
      check("rst_start",   GCD_START,   1'b0);
      check("rst_timeout", TIMEOUT,     1'b0);
      check("rst_res",     RESULT_A | RESULT_B, '0);
      check("rst_gcd",     GCD_A | GCD_B, '0);
      check("rst_busy",    BUSY_CYCLES, '0);
      tick();
      RESETn = 1'b1;
      repeat (8) tick();
      check("zero_args_no_launch", start_count, 0);

      // 1: single write A=48 B=18, core answers after 5 cycles.
      core_n = 5;
      s0 = start_count;
      ARG_A = 48; ARG_B = 18;
      c = int'(cyc);
      wait_sig(0, "s1_start", 20, s);
      check("s1_start_delay", s - c, 5);
      check("s1_gcd_a", GCD_A, 48);
      check("s1_gcd_b", GCD_B, 18);
      wait_sig(2, "s1_core_done", 20, g);
      wait_sig(1, "s1_done", 5, dn);
      check("s1_done_delay", dn - g, 1);
      check("s1_result_a", RESULT_A, 6);
      check("s1_result_b", RESULT_B, 144);
      check("s1_busy", BUSY_CYCLES, 5);
      check("s1_timeout", TIMEOUT, 1'b0);
      check("s1_one_start", start_count - s0, 1);

      // 2: ARG_A toggles every 3 cycles, then holds.
      tick();
      s0 = start_count;
      for (int k = 0; k < 7; k++) begin
         ARG_A = ARG_W'(40 + 5 * k);
         if (k < 6) repeat (3) tick();
      end
      c = int'(cyc);
      wait_sig(0, "s2_start", 20, s);
      check("s2_start_delay", s - c, 5);
      wait_sig(1, "s2_done", 30, dn);
      check("s2_one_start", start_count - s0, 1);
      check("s2_result_a", RESULT_A, 2);

      // 3: ARG_B changes during BUSY, first result discarded.
      core_n = 8;
      tick();
      ARG_A = 48; ARG_B = 18;
      wait_sig(0, "s3_start", 20, s);
      repeat (3) tick();
      ARG_B = 21;
      wait_sig(2, "s3_core_done", 20, g);
      @(negedge CLK);
      check("s3_discard_done", DONE, 1'b0);
      wait_sig(0, "s3_restart", 20, s2);
      check("s3_restart_delay", s2 - g, 5);
      check("s3_gcd_a", GCD_A, 48);
      check("s3_gcd_b", GCD_B, 21);
      wait_sig(1, "s3_done", 30, dn);
      check("s3_result_a", RESULT_A, 3);
      check("s3_result_b", RESULT_B, 336);
      check("s3_busy", BUSY_CYCLES, 8);

      // 5: change in HOLD, old results held until the new capture.
      core_n = 5;
      tick();
      ARG_A = 100;
      @(negedge CLK);
      check("s5_done_before", DONE, 1'b1);
      @(negedge CLK);
      check("s5_done_drop", DONE, 1'b0);
      check("s5_hold_old", RESULT_A, 3);
      wait_sig(2, "s5_core_done", 30, g);
      check("s5_old_at_core_done", RESULT_A, 3);
      wait_sig(1, "s5_done", 5, dn);
      check("s5_result_a", RESULT_A, 1);
      check("s5_result_b", RESULT_B, 2100);

      // 4: core never answers, timeout after 16 BUSY cycles.
      core_n = 0;
      tick();
      ARG_A = 35; ARG_B = 14;
      wait_sig(0, "s4_start", 20, s);
      wait_sig(1, "s4_done", 40, dn);
      check("s4_done_delay", dn - s, 17);
      check("s4_timeout", TIMEOUT, 1'b1);
      check("s4_result_a", RESULT_A, 0);
      check("s4_result_b", RESULT_B, 0);
      check("s4_busy", BUSY_CYCLES, 16);

      // 6: reset pulse mid-BUSY, late core completion ignored.
      core_n = 6;
      tick();
      ARG_A = 27; ARG_B = 9;
      wait_sig(0, "s6_start", 20, s);
      repeat (3) tick();
      RESETn = 1'b0;
      ARG_A = 0; ARG_B = 0;
      tick();
      RESETn = 1'b1;
      s0 = start_count;
      @(negedge CLK);
      check("s6_done",    DONE,        1'b0);
      check("s6_start",   GCD_START,   1'b0);
      check("s6_timeout", TIMEOUT,     1'b0);
      check("s6_res",     RESULT_A | RESULT_B, '0);
      check("s6_gcd",     GCD_A | GCD_B, '0);
      check("s6_busy",    BUSY_CYCLES, '0);
      wait_sig(2, "s6_late_core_done", 10, g);
      repeat (6) tick();
      @(negedge CLK);
      check("s6_done_stays_low", DONE, 1'b0);
      check("s6_no_start", start_count - s0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
